// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type encodings and the output-link framing states.
// Used by the link transmitter, the input buffers and the routing logic.
package noc_pkg;

  typedef enum logic [1:0] {
    FLIT_BODY     = 2'b00,
    FLIT_HEAD     = 2'b01,
    FLIT_TAIL     = 2'b10,
    FLIT_HEADTAIL = 2'b11
  } flit_type_e;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_PKT  = 1'b1
  } tx_state_e;

  // TAIL and HEADTAIL both close a packet; they share the upper type bit.
  function automatic logic is_pkt_end(input logic [1:0] flit_type);
    return flit_type[1];
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Single-clock circular FIFO with occupancy count. Push while full and pop while
// empty are ignored, so callers may pass unqualified requests.
module noc_sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   occ
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_OCC = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (occ_q == DEPTH_OCC);
  assign empty   = (occ_q == '0);
  assign occ     = occ_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Pointers are exactly AW bits wide, so a power-of-two depth wraps for free.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   occ_d = occ_q + (AW+1)'(1);
      2'b01:   occ_d = occ_q - (AW+1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage is deliberately not reset; readers mask dout while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/noc_link_tx.sv
// Router output-link transmitter: buffers granted flits, drives them over a
// valid/ready link, polices head/body/tail framing and counts sent packets.
module noc_link_tx
  import noc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [1:0]              wr_type,
  input  logic [DATA_W-1:0]       wr_data,
  output logic                    ready_out,
  output logic                    tx_valid,
  output logic [1:0]              tx_type,
  output logic [DATA_W-1:0]       tx_data,
  input  logic                    tx_ready,
  output logic                    pkt_sent,
  output logic [CNT_W-1:0]        pkt_count,
  output logic                    err_overflow,
  output logic                    err_framing,
  output logic                    dbg_state,
  output logic [$clog2(DEPTH):0]  dbg_occ
);

  // Link handshake: a flit transfers on a rising edge where tx_valid & tx_ready.
  // tx_valid never depends on tx_ready, and tx_type/tx_data stay stable while stalled.

  tx_state_e           state_q, state_d;
  logic                err_overflow_q, err_framing_q;
  logic                pkt_sent_q;
  logic [CNT_W-1:0]    pkt_count_q;
  logic                frame_ok;
  logic                frame_err;
  logic                accept;
  logic                send;
  logic                fifo_full;
  logic                fifo_empty;
  logic [DATA_W+1:0]   fifo_dout;

  noc_sync_fifo #(
    .W     (DATA_W + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (send),
    .din   ({wr_type, wr_data}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .occ   (dbg_occ)
  );

  // ready_out comes straight from the registered occupancy; a send in the same
  // cycle does not make room for a write.
  assign ready_out = ~fifo_full;
  assign tx_valid  = ~fifo_empty;
  assign {tx_type, tx_data} = tx_valid ? fifo_dout : '0;

  assign accept = wr_en & ready_out & frame_ok;
  assign send   = tx_valid & tx_ready;

  // Framing only looks at writes that the buffer could take; refused writes
  // leave the state alone.
  always_comb begin
    state_d   = state_q;
    frame_ok  = 1'b1;
    frame_err = 1'b0;
    if (wr_en && ready_out) begin
      case (state_q)
        TX_IDLE: begin
          case (flit_type_e'(wr_type))
            FLIT_HEAD:     state_d = TX_PKT;
            FLIT_HEADTAIL: state_d = TX_IDLE;
            default: begin
              frame_ok  = 1'b0;
              frame_err = 1'b1;
            end
          endcase
        end
        TX_PKT: begin
          case (flit_type_e'(wr_type))
            FLIT_BODY:     state_d = TX_PKT;
            FLIT_TAIL:     state_d = TX_IDLE;
            FLIT_HEAD:     frame_err = 1'b1;
            FLIT_HEADTAIL: begin
              frame_err = 1'b1;
              state_d   = TX_IDLE;
            end
            default:       state_d = TX_PKT;
          endcase
        end
        default: state_d = TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= TX_IDLE;
      err_overflow_q <= 1'b0;
      err_framing_q  <= 1'b0;
      pkt_sent_q     <= 1'b0;
      pkt_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      err_overflow_q <= err_overflow_q | (wr_en & ~ready_out);
      err_framing_q  <= err_framing_q | frame_err;
      pkt_sent_q     <= send & is_pkt_end(tx_type);
      if (send && is_pkt_end(tx_type)) pkt_count_q <= pkt_count_q + CNT_W'(1);
    end
  end

  assign pkt_sent     = pkt_sent_q;
  assign pkt_count    = pkt_count_q;
  assign err_overflow = err_overflow_q;
  assign err_framing  = err_framing_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_noc_link_tx.sv
// Bench for noc_link_tx: directed scenarios plus random traffic, checked against
// a queue-based reference model and a link-side scoreboard.
module tb_noc_link_tx;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 16;
  localparam int FW     = DATA_W + 2;
  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_HT   = 2'b11;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    wr_en;
  logic [1:0]              wr_type;
  logic [DATA_W-1:0]       wr_data;
  logic                    ready_out;
  logic                    tx_valid;
  logic [1:0]              tx_type;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_ready;
  logic                    pkt_sent;
  logic [CNT_W-1:0]        pkt_count;
  logic                    err_overflow;
  logic                    err_framing;
  logic                    dbg_state;
  logic [$clog2(DEPTH):0]  dbg_occ;

  noc_link_tx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_type      (wr_type),
    .wr_data      (wr_data),
    .ready_out    (ready_out),
    .tx_valid     (tx_valid),
    .tx_type      (tx_type),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .pkt_sent     (pkt_sent),
    .pkt_count    (pkt_count),
    .err_overflow (err_overflow),
    .err_framing  (err_framing),
    .dbg_state    (dbg_state),
    .dbg_occ      (dbg_occ)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model + scoreboard ----------------
  logic [FW-1:0] m_buf[$];
  logic [FW-1:0] exp_q[$];
  bit            m_in_pkt;
  bit            m_ovf;
  bit            m_ferr;
  bit            m_sent;
  int            m_cnt;
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_status();
    chk("ready_out", 64'(ready_out), 64'(m_buf.size() < DEPTH));
    chk("tx_valid", 64'(tx_valid), 64'(m_buf.size() != 0));
    chk("occ", 64'(dbg_occ), 64'(m_buf.size()));
    if (m_buf.size() != 0) chk("tx_head", 64'({tx_type, tx_data}), 64'(m_buf[0]));
    else                   chk("tx_masked", 64'({tx_type, tx_data}), 64'(0));
    chk("pkt_sent", 64'(pkt_sent), 64'(m_sent));
    chk("pkt_count", 64'(pkt_count), 64'(m_cnt % (1 << CNT_W)));
    chk("err_overflow", 64'(err_overflow), 64'(m_ovf));
    chk("err_framing", 64'(err_framing), 64'(m_ferr));
    chk("fsm_state", 64'(dbg_state), 64'(m_in_pkt));
  endtask

  task automatic model_clear();
    m_buf.delete();
    exp_q.delete();
    m_in_pkt = 0;
    m_ovf    = 0;
    m_ferr   = 0;
    m_sent   = 0;
    m_cnt    = 0;
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; drives one cycle and advances the model.
  task automatic step(input bit we, input logic [1:0] ty, input logic [DATA_W-1:0] d, input bit rdy);
    bit            room;
    bit            send;
    bit            store;
    logic [FW-1:0] f;
    wr_en    = we;
    wr_type  = ty;
    wr_data  = d;
    tx_ready = rdy;
    @(negedge clk);
    check_status();
    room  = m_buf.size() < DEPTH;
    send  = (m_buf.size() > 0) && rdy;
    store = 0;
    m_sent = 0;
    if (send) begin
      f = m_buf.pop_front();
      if (f[FW-1:FW-2] == T_TAIL || f[FW-1:FW-2] == T_HT) begin
        m_sent = 1;
        m_cnt++;
      end
    end
    if (we && !room) m_ovf = 1;
    else if (we) begin
      if (!m_in_pkt) begin
        case (ty)
          T_HEAD:  begin store = 1; m_in_pkt = 1; end
          T_HT:    store = 1;
          default: m_ferr = 1;
        endcase
      end else begin
        store = 1;
        case (ty)
          T_TAIL:  m_in_pkt = 0;
          T_HEAD:  m_ferr = 1;
          T_HT:    begin m_ferr = 1; m_in_pkt = 0; end
          default: ;
        endcase
      end
    end
    if (store) begin
      m_buf.push_back({ty, d});
      exp_q.push_back({ty, d});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr_en    = 0;
    tx_ready = 0;
    rst      = 1;
    @(posedge clk);
    #1;
    rst = 0;
    model_clear();
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DEPTH && m_buf.size() > 0; i++) step(0, T_BODY, '0, 1);
    step(0, T_BODY, '0, 1);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got %0h expected nothing at %0t", {tx_type, tx_data}, $time);
      end else begin
        chk("sb_flit", 64'({tx_type, tx_data}), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int sent_i;
    rst      = 1;
    wr_en    = 0;
    wr_type  = '0;
    wr_data  = '0;
    tx_ready = 0;
    model_clear();
    do_reset();
    step(0, T_BODY, '0, 0);

    // basic send
    step(1, T_HEAD, 32'hA, 1);
    step(1, T_BODY, 32'hB, 1);
    step(1, T_TAIL, 32'hC, 1);
    drain();
    chk("basic_count", 64'(pkt_count), 64'(1));

    // backpressure until full, fifth write dropped
    do_reset();
    step(1, T_HEAD, 32'h10, 0);
    step(1, T_BODY, 32'h11, 0);
    step(1, T_BODY, 32'h12, 0);
    step(1, T_BODY, 32'h13, 0);
    step(1, T_TAIL, 32'h14, 0);
    step(0, T_BODY, '0, 0);
    chk("bp_overflow", 64'(err_overflow), 64'(1));

    // full + send in the same cycle refuses the write; then write+send at occ=3
    step(1, T_BODY, 32'h15, 1);
    chk("simul_occ3", 64'(dbg_occ), 64'(3));
    step(1, T_TAIL, 32'h16, 1);
    chk("simul_occ_hold", 64'(dbg_occ), 64'(3));
    drain();

    // framing
    do_reset();
    step(1, T_BODY, 32'h5, 0);
    step(1, T_HEAD, 32'h6, 0);
    step(1, T_HEAD, 32'h7, 0);
    step(0, T_BODY, '0, 0);
    chk("frame_pkt", 64'(dbg_state), 64'(1));
    drain();

    // wrap-around with random backpressure
    do_reset();
    sent_i = 0;
    for (int c = 0; c < 200 && sent_i < 10; c++) begin
      if (m_buf.size() < DEPTH) begin
        step(1, T_HT, DATA_W'(sent_i), 1'($urandom_range(0, 1)));
        sent_i++;
      end else begin
        step(0, T_BODY, '0, 1'($urandom_range(0, 1)));
      end
    end
    drain();
    chk("wrap_count", 64'(pkt_count), 64'(10));

    // reset mid-packet
    step(1, T_HEAD, 32'h20, 0);
    step(1, T_BODY, 32'h21, 0);
    do_reset();
    step(0, T_BODY, '0, 1);
    step(1, T_BODY, 32'h22, 1);
    step(0, T_BODY, '0, 1);
    chk("rst_body_err", 64'(err_framing), 64'(1));

    // random traffic
    do_reset();
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                DATA_W'($urandom), 1'($urandom_range(0, 2) != 0));
    end
    drain();
    chk("sb_empty", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
